ls_stage_reg: RTL and testbench
===============================

Name: ls_stage_reg

Overview:
- Parametrised execute-to-load/store pipeline stage register. Successor to the fixed, always-loading EX/LS register.
- Carries PC, instruction, rs2 data, ALU result and a generic control bundle (mem_wren, mem_lden, mem_op, …).
- Adds a valid/ready handshake, stall back-pressure and flush (bubble insertion).
- Sits between the EXU and LSU in the pipelined core.

Parameters:
- XLEN, 64, width of PC, rs2 and ALU-result fields.
- ILEN, 32, instruction width.
- CTRL_W, 5, width of the control bundle (1 wren + 1 lden + 3 mem_op).
- NOP_INSTR, 32'h0000_0013, instruction value driven when the stage holds a bubble.

Ports:
- clk  in  1  core clock.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream holds a valid instruction.
- in_ready  out  1  stage accepts this cycle.
- pc_i  in  XLEN  PC.
- instr_i  in  ILEN  instruction.
- rs2_i  in  XLEN  store data.
- alures_i  in  XLEN  ALU result / address.
- ctrl_i  in  CTRL_W  memory control bundle.
- flush  in  1  kill the held and incoming instruction.
- out_valid  out  1  output payload is valid.
- out_ready  in  1  LSU consumes this cycle.
- pc_o  out  XLEN  registered PC.
- instr_o  out  ILEN  registered instruction.
- rs2_o  out  XLEN  registered store data.
- alures_o  out  XLEN  registered ALU result.
- ctrl_o  out  CTRL_W  registered control bundle.

Behaviour:
- Reset (rst=1 at posedge): out_valid=0, pc_o=0, rs2_o=0, alures_o=0, ctrl_o=0, instr_o=NOP_INSTR. in_ready=1 from the first cycle after reset. Reset mid-transfer drops the held instruction; there is no partial output.
- Transfer rules:
  - Input handshake = in_valid & in_ready.
  - Output handshake = out_valid & out_ready.
  - Latency is 1 cycle, throughput 1/cycle.
- State machine, base build, 2 states:
  - EMPTY (out_valid=0): input handshake → FULL; otherwise stay.
  - FULL (out_valid=1):
    - out_ready & input handshake → stay FULL with the new payload.
    - out_ready & no input → EMPTY.
    - ~out_ready → hold; payload stable, no bit may change.
- in_ready = ~out_valid | out_ready (combinational, base build only).
- Flush has priority over all other events. At posedge with flush=1:
  - next state EMPTY, out_valid=0;
  - ctrl_o=0 (wren/lden forced low so no memory side effect), instr_o=NOP_INSTR;
  - other payload fields are don't-care, but the implementation clears them to 0;
  - the incoming instruction is discarded even if in_valid & in_ready.
- Payload is loaded only on an input handshake; it never changes while out_valid & ~out_ready.
- In EMPTY without flush, payload holds its last value; consumers qualify by out_valid.
- No arithmetic; all fields pass through at full width.

Optional Feature:
- Macro LS_STAGE_SKID_EN.
- When defined: a one-entry skid buffer is added and in_ready becomes a registered signal (no combinational path from out_ready). States are EMPTY, BUSY (main full), FULL (main + skid full).
  - BUSY & input & ~out_ready → FULL, skid captures the input; in_ready=0 next cycle.
  - FULL & out_ready → BUSY, skid moves to main; in_ready=1 next cycle.
  - in_ready = (state != FULL).
  - Flush clears both entries → EMPTY.
- When undefined: the 2-state base behaviour above, with the combinational in_ready.

Decomposition:
- Shared package/defines holds:
  - XLEN and ILEN defaults;
  - NOP_INSTR;
  - ls_ctrl bit-position constants (CTRL_WREN=0, CTRL_LDEN=1, CTRL_OP=4:2);
  - state encodings EMPTY=2'd0, BUSY=2'd1, FULL=2'd2.
- One natural sub-module: ls_stage_payload_reg, a width-parametrised enabled register with synchronous clear-to-value. It is instantiated for the main entry and, under LS_STAGE_SKID_EN, for the skid entry.

Test Plan:
- Reset then stream: in_valid=1, out_ready=1, pc_i=0x8000_0000 / 0x8000_0004 / 0x8000_0008 on consecutive cycles → pc_o shows the same sequence 1 cycle later, out_valid=1 each cycle, in_ready stays 1.
- Stall: FULL with pc_o=0x8000_0010, out_ready=0 for 3 cycles while in_valid=1 → pc_o and all fields unchanged; in_ready=0 (base) or 1 then 0 (skid); once out_ready=1, next pc_o = the stalled input, nothing dropped or duplicated.
- Flush during store: FULL with ctrl_o wren=1, flush=1 together with in_valid=1 → next cycle out_valid=0, ctrl_o=0, instr_o=32'h0000_0013; incoming PC never appears on pc_o.
- Synchronous reset mid-stall: FULL, out_ready=0, rst=1 for one cycle → next cycle out_valid=0, instr_o=NOP_INSTR, all other outputs 0; rst asserted between edges does not affect outputs before the posedge.
- Random valid/ready scoreboard: 10,000 cycles, ~50% duty on both sides, random flush at 2% → output order equals input order minus flushed entries; zero loss or duplication in both macro builds.
- Skid only: out_ready=0 with 2 inputs accepted → in_ready deasserts at the cycle after the second accept; releasing out_ready drains the 2 entries in order on consecutive cycles.

Source files
------------

// File: rtl/ls_stage_reg_pkg.sv
// Shared definitions for the execute-to-load/store stage register: field
// widths, bubble instruction, control-bundle bit positions, state encoding.
package ls_stage_reg_pkg;

  localparam int XLEN_DEF   = 64;
  localparam int ILEN_DEF   = 32;
  localparam int CTRL_W_DEF = 5;

  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0013;

  localparam int CTRL_WREN   = 0;
  localparam int CTRL_LDEN   = 1;
  localparam int CTRL_OP_LSB = 2;
  localparam int CTRL_OP_MSB = 4;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } ls_state_e;

endpackage

// File: rtl/ls_stage_payload_reg.sv
// Width-parametrised payload register: load on enable, synchronous clear to a
// fixed value (clear wins over load).
module ls_stage_payload_reg
  import ls_stage_reg_pkg::*;
#(
  parameter int           W       = 8,
  parameter logic [W-1:0] CLR_VAL = '0
) (
  input  logic         clk,
  input  logic         clr,
  input  logic         en,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  always_ff @(posedge clk) begin
    if (clr) begin
      q <= CLR_VAL;
    end else if (en) begin
      q <= d;
    end
  end

endmodule

// File: rtl/ls_stage_reg.sv
// EX/LS pipeline stage register with valid/ready handshake, stall and flush.
// Define LS_STAGE_SKID_EN for a registered in_ready backed by a one-entry skid buffer.
module ls_stage_reg
  import ls_stage_reg_pkg::*;
#(
  parameter int               XLEN      = XLEN_DEF,
  parameter int               ILEN      = ILEN_DEF,
  parameter int               CTRL_W    = CTRL_W_DEF,
  parameter logic [ILEN-1:0]  NOP_INSTR = ILEN'(NOP_INSTR_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [XLEN-1:0]   pc_i,
  input  logic [ILEN-1:0]   instr_i,
  input  logic [XLEN-1:0]   rs2_i,
  input  logic [XLEN-1:0]   alures_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [XLEN-1:0]   pc_o,
  output logic [ILEN-1:0]   instr_o,
  output logic [XLEN-1:0]   rs2_o,
  output logic [XLEN-1:0]   alures_o,
  output logic [CTRL_W-1:0] ctrl_o
);

  localparam int PW = 3*XLEN + ILEN + CTRL_W;
  // Bubble: everything zero except the instruction slot, which carries NOP.
  localparam logic [PW-1:0] CLR_VAL = {{XLEN{1'b0}}, NOP_INSTR, {(2*XLEN+CTRL_W){1'b0}}};

  ls_state_e       state_q, state_d;
  logic            main_en;
  logic            clr;
  logic            in_hs;
  logic [PW-1:0]   pay_in;
  logic [PW-1:0]   main_d;
  logic [PW-1:0]   main_q;

  assign pay_in    = {pc_i, instr_i, rs2_i, alures_i, ctrl_i};
  assign clr       = rst | flush;
  assign in_hs     = in_valid & in_ready;
  assign out_valid = (state_q != EMPTY);
  assign {pc_o, instr_o, rs2_o, alures_o, ctrl_o} = main_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

`ifdef LS_STAGE_SKID_EN
  logic          skid_en;
  logic [PW-1:0] skid_q;

  // in_ready depends only on the state flop, never on out_ready.
  assign in_ready = (state_q != FULL);
  assign main_d   = (state_q == FULL) ? skid_q : pay_in;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    skid_en = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          state_d = BUSY;
          main_en = 1'b1;
        end
      end
      BUSY: begin
        if (out_ready) begin
          if (in_hs) main_en = 1'b1;
          else       state_d = EMPTY;
        end else if (in_hs) begin
          state_d = FULL;
          skid_en = 1'b1;
        end
      end
      FULL: begin
        if (out_ready) begin
          state_d = BUSY;
          main_en = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end

  ls_stage_payload_reg #(.W(PW), .CLR_VAL(CLR_VAL)) u_skid (
    .clk (clk),
    .clr (clr),
    .en  (skid_en),
    .d   (pay_in),
    .q   (skid_q)
  );
`else
  assign in_ready = ~out_valid | out_ready;
  assign main_d   = pay_in;

  always_comb begin
    state_d = state_q;
    main_en = 1'b0;
    case (state_q)
      EMPTY: begin
        if (in_hs) begin
          state_d = FULL;
          main_en = 1'b1;
        end
      end
      FULL: begin
        if (out_ready) begin
          if (in_hs) main_en = 1'b1;
          else       state_d = EMPTY;
        end
      end
      default: state_d = EMPTY;
    endcase
    if (flush) state_d = EMPTY;
  end
`endif

  ls_stage_payload_reg #(.W(PW), .CLR_VAL(CLR_VAL)) u_main (
    .clk (clk),
    .clr (clr),
    .en  (main_en),
    .d   (main_d),
    .q   (main_q)
  );

endmodule

// File: tb/tb_ls_stage_reg.sv
// Self-checking bench for ls_stage_reg: directed vector table, skid-only
// sequence, and a randomized run against a queue-based reference model.
module tb_ls_stage_reg;

`ifdef LS_STAGE_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  localparam logic [31:0] NOP = 32'h0000_0013;
  localparam logic [63:0] B   = 64'h8000_0000;

  typedef struct packed {
    logic [63:0] pc;
    logic [31:0] instr;
    logic [63:0] rs2;
    logic [63:0] alu;
    logic [4:0]  ctrl;
  } pay_t;

  typedef struct {
    logic        rst, iv, fl, ory;
    logic [63:0] pc;
    logic [4:0]  ctrl;
    logic        chk, e_ov, e_irb, e_irs, e_clr;
    logic [63:0] e_pc;
    logic [4:0]  e_ctrl;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst, in_valid, in_ready, flush, out_valid, out_ready;
  logic [63:0] pc_i, rs2_i, alures_i, pc_o, rs2_o, alures_o;
  logic [31:0] instr_i, instr_o;
  logic [4:0]  ctrl_i, ctrl_o;
  pay_t        dut_pay;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  ls_stage_reg #(.XLEN(64), .ILEN(32), .CTRL_W(5), .NOP_INSTR(32'h0000_0013)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .pc_i(pc_i), .instr_i(instr_i), .rs2_i(rs2_i), .alures_i(alures_i), .ctrl_i(ctrl_i),
    .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .pc_o(pc_o), .instr_o(instr_o), .rs2_o(rs2_o), .alures_o(alures_o), .ctrl_o(ctrl_o)
  );

  always_comb dut_pay = {pc_o, instr_o, rs2_o, alures_o, ctrl_o};

  function automatic pay_t mk(input logic [63:0] pc, input logic [4:0] ctrl);
    pay_t p;
    p.pc    = pc;
    p.instr = pc[31:0] ^ 32'hA5A5_0000;
    p.rs2   = pc + 64'd1;
    p.alu   = pc + 64'd2;
    p.ctrl  = ctrl;
    return p;
  endfunction

  function automatic pay_t clr_pay();
    pay_t p;
    p       = '0;
    p.instr = NOP;
    return p;
  endfunction

  function automatic vec_t mkv(input logic r, iv, fl, ory, input logic [63:0] pc,
                               input logic [4:0] ctrl, input logic chk, e_ov, e_irb,
                               e_irs, e_clr, input logic [63:0] e_pc, input logic [4:0] e_ctrl);
    vec_t v;
    v.rst = r; v.iv = iv; v.fl = fl; v.ory = ory; v.pc = pc; v.ctrl = ctrl;
    v.chk = chk; v.e_ov = e_ov; v.e_irb = e_irb; v.e_irs = e_irs; v.e_clr = e_clr;
    v.e_pc = e_pc; v.e_ctrl = e_ctrl;
    return v;
  endfunction

  task automatic chk_bit(input string nm, input logic act, input logic exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %b expected %b", nm, act, exp);
    end
  endtask

  task automatic chk_pay(input string nm, input pay_t act, input pay_t exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input logic r, input logic iv, input pay_t p, input logic fl, input logic ory);
    rst       = r;
    in_valid  = iv;
    pc_i      = p.pc;
    instr_i   = p.instr;
    rs2_i     = p.rs2;
    alures_i  = p.alu;
    ctrl_i    = p.ctrl;
    flush     = fl;
    out_ready = ory;
  endtask

  vec_t tbl [19];
  pay_t q [$];
  pay_t last, exp_pay, p;
  logic exp_ov, exp_ir, iv, ory, fl;

  initial begin
    drive(1'b1, 1'b0, '0, 1'b0, 1'b0);

    //        rst iv fl ory pc       ctrl  chk ov irb irs clr e_pc     e_ctrl
    tbl[0]  = mkv(1, 0, 0, 0, 64'h0,   5'd0, 0, 0, 0, 0, 0, 64'h0,   5'd0);
    tbl[1]  = mkv(0, 1, 0, 1, B,       5'd0, 1, 0, 1, 1, 1, 64'h0,   5'd0);
    tbl[2]  = mkv(0, 1, 0, 1, B+4,     5'd0, 1, 1, 1, 1, 0, B,       5'd0);
    tbl[3]  = mkv(0, 1, 0, 1, B+8,     5'd0, 1, 1, 1, 1, 0, B+4,     5'd0);
    tbl[4]  = mkv(0, 1, 0, 1, B+'h10,  5'd0, 1, 1, 1, 1, 0, B+8,     5'd0);
    tbl[5]  = mkv(0, 1, 0, 0, B+'h14,  5'd0, 1, 1, 0, 1, 0, B+'h10,  5'd0);
    tbl[6]  = mkv(0, 1, 0, 0, B+'h14,  5'd0, 1, 1, 0, 0, 0, B+'h10,  5'd0);
    tbl[7]  = mkv(0, 1, 0, 0, B+'h14,  5'd0, 1, 1, 0, 0, 0, B+'h10,  5'd0);
    tbl[8]  = mkv(0, 1, 0, 1, B+'h14,  5'd0, 1, 1, 1, 0, 0, B+'h10,  5'd0);
    tbl[9]  = mkv(0, 1, 0, 1, B+'h18,  5'd1, 1, 1, 1, 1, 0, B+'h14,  5'd0);
    tbl[10] = mkv(0, 1, 1, 0, B+'h1C,  5'd0, 1, 1, 0, 1, 0, B+'h18,  5'd1);
    tbl[11] = mkv(0, 0, 0, 1, 64'h0,   5'd0, 1, 0, 1, 1, 1, 64'h0,   5'd0);
    tbl[12] = mkv(0, 1, 0, 1, B+'h20,  5'd2, 1, 0, 1, 1, 1, 64'h0,   5'd0);
    tbl[13] = mkv(0, 1, 0, 0, B+'h24,  5'd0, 1, 1, 0, 1, 0, B+'h20,  5'd2);
    tbl[14] = mkv(1, 1, 0, 0, B+'h28,  5'd0, 1, 1, 0, 0, 0, B+'h20,  5'd2);
    tbl[15] = mkv(0, 0, 0, 0, 64'h0,   5'd0, 1, 0, 1, 1, 1, 64'h0,   5'd0);
    tbl[16] = mkv(0, 1, 0, 0, B+'h30,  5'd0, 1, 0, 1, 1, 1, 64'h0,   5'd0);
    tbl[17] = mkv(0, 0, 0, 1, 64'h0,   5'd0, 1, 1, 1, 1, 0, B+'h30,  5'd0);
    tbl[18] = mkv(0, 0, 0, 1, 64'h0,   5'd0, 1, 0, 1, 1, 0, B+'h30,  5'd0);

    for (int i = 0; i < 19; i++) begin
      @(negedge clk);
      drive(tbl[i].rst, tbl[i].iv, mk(tbl[i].pc, tbl[i].ctrl), tbl[i].fl, tbl[i].ory);
      #1;
      if (tbl[i].chk) begin
        chk_bit($sformatf("row%0d out_valid", i), out_valid, tbl[i].e_ov);
        chk_bit($sformatf("row%0d in_ready", i), in_ready, SKID ? tbl[i].e_irs : tbl[i].e_irb);
        chk_pay($sformatf("row%0d payload", i), dut_pay,
                tbl[i].e_clr ? clr_pay() : mk(tbl[i].e_pc, tbl[i].e_ctrl));
      end
    end

`ifdef LS_STAGE_SKID_EN
    // Two accepts under stall fill main + skid, then drain in order.
    @(negedge clk); drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(negedge clk); drive(1'b0, 1'b1, mk(B+'h40, 5'd0), 1'b0, 1'b0); #1;
    chk_bit("skid accept1 in_ready", in_ready, 1'b1);
    @(negedge clk); drive(1'b0, 1'b1, mk(B+'h44, 5'd0), 1'b0, 1'b0); #1;
    chk_bit("skid accept2 in_ready", in_ready, 1'b1);
    chk_pay("skid accept2 payload", dut_pay, mk(B+'h40, 5'd0));
    @(negedge clk); drive(1'b0, 1'b1, mk(B+'h48, 5'd0), 1'b0, 1'b0); #1;
    chk_bit("skid full in_ready", in_ready, 1'b0);
    @(negedge clk); drive(1'b0, 1'b0, '0, 1'b0, 1'b1); #1;
    chk_pay("skid drain1 payload", dut_pay, mk(B+'h40, 5'd0));
    @(negedge clk); #1;
    chk_bit("skid drain2 out_valid", out_valid, 1'b1);
    chk_pay("skid drain2 payload", dut_pay, mk(B+'h44, 5'd0));
    @(negedge clk); #1;
    chk_bit("skid drained out_valid", out_valid, 1'b0);
`endif

    // Randomized run against a FIFO-of-accepted-entries model.
    @(negedge clk); drive(1'b1, 1'b0, '0, 1'b0, 1'b0);
    @(posedge clk);
    q.delete();
    last = clr_pay();
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      iv      = 1'($urandom_range(0, 1));
      ory     = 1'($urandom_range(0, 1));
      fl      = ($urandom_range(0, 99) < 2);
      p.pc    = {32'h9000_0000, 32'(n) << 2};
      p.instr = $urandom;
      p.rs2   = {$urandom, $urandom};
      p.alu   = {$urandom, $urandom};
      p.ctrl  = 5'($urandom);
      drive(1'b0, iv, p, fl, ory);
      #1;
      exp_ov  = (q.size() != 0);
      exp_ir  = SKID ? (q.size() < 2) : (q.size() == 0 || ory);
      exp_pay = (q.size() != 0) ? q[0] : last;
      chk_bit($sformatf("rand%0d out_valid", n), out_valid, exp_ov);
      chk_bit($sformatf("rand%0d in_ready", n), in_ready, exp_ir);
      chk_pay($sformatf("rand%0d payload", n), dut_pay, exp_pay);
      @(posedge clk);
      last = exp_pay;
      if (fl) begin
        q.delete();
        last = clr_pay();
      end else begin
        if (exp_ov && ory) void'(q.pop_front());
        if (iv && exp_ir) q.push_back(p);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
